// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single port of the data RAM between the pipeline MEM stage and a
// debug read requester. The pipeline owns the port by default. A debug read is
// slotted into a cycle where the MEM stage does not use the RAM. The read
// returns in dbg_rdata together with a one-cycle dbg_ack, two cycles after the
// grant cycle.
//
// Optional feature (compile-time macro DMEM_ARB_STARVE_EN):
//   When defined, a starvation counter tracks how many IDLE cycles a pending
//   debug request has lost to the pipeline. Once the count reaches
//   STARVE_LIMIT, the grant is forced and the pipeline is stalled for that one
//   cycle. When undefined, no counter exists, pipe_stall is constant 0 and
//   debug is granted only in cycles with pipe_en = 0.
//
// Parameters
//   ADDR_W        word-address width of the shared data RAM
//   STARVE_LIMIT  waiting cycles before a forced debug grant (starvation build)
//
// Ports
//   clk          single clock, all state on rising edge
//   reset        asynchronous, active-high reset
//   pipe_en      MEM-stage access valid this cycle
//   pipe_we      MEM-stage byte write enables (0000 = read)
//   pipe_addr    MEM-stage word address
//   pipe_wdata   MEM-stage store data
//   pipe_stall   freeze pipeline; MEM access not performed this cycle
//   dbg_req      debug read request, level, held until dbg_ack
//   dbg_addr     debug read word address, stable while dbg_req is high
//   dbg_ack      one-cycle pulse, dbg_rdata valid
//   dbg_rdata    registered debug read data, held until the next capture
//   ram_wea      RAM byte write enables
//   ram_addra    RAM word address
//   ram_dina     RAM write data
//   ram_douta    RAM read data (1-cycle synchronous read latency)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_en,
  input  logic [3:0]        pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [31:0]       pipe_wdata,
  output logic              pipe_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DBG_RD  = 2'd1;
  localparam logic [1:0] DBG_ACK = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        grant_s;
  logic        force_s;
  logic        dbg_ack_r;
  logic [31:0] dbg_rdata_r;

`ifdef DMEM_ARB_STARVE_EN
  // Wide enough to hold STARVE_LIMIT itself; at least one bit.
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_r;
  logic             waiting_s;

  // A request is losing to the pipeline only while we sit in IDLE.
  assign waiting_s = (state_r == IDLE) && dbg_req && pipe_en;
  assign force_s   = waiting_s && (starve_cnt_r >= CNT_LIMIT);

  // Starvation counter: count lost cycles, clear whenever debug is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (waiting_s) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  // No starvation counter in this build: a forced grant can never happen.
  // The comparison is false for every legal STARVE_LIMIT and keeps the
  // parameter referenced so both builds share one parameter list.
  assign force_s = (STARVE_LIMIT < 0);
`endif

  // Debug wins the port in IDLE when the pipeline leaves it free, or when the
  // starvation limit has been reached.
  assign grant_s = (state_r == IDLE) && dbg_req && (!pipe_en || force_s);

  // Next-state logic for the debug read sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = DBG_RD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DBG_RD:  state_nxt_s = DBG_ACK;
      // dbg_req is still high here but must not start a second read.
      DBG_ACK: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; reset aborts any debug read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Acknowledge is the cycle after the capture cycle, exactly one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_ack_r <= 1'b0;
    end else begin
      dbg_ack_r <= (state_r == DBG_RD);
    end
  end

  // Capture RAM read data during DBG_RD; hold it until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_rdata_r <= 32'h0000_0000;
    end else if (state_r == DBG_RD) begin
      dbg_rdata_r <= ram_douta;
    end else begin
      dbg_rdata_r <= dbg_rdata_r;
    end
  end

  // RAM port mux. The pipeline owns the port in every cycle except the debug
  // grant cycle. Reset forces a read so that no write can reach the RAM while
  // reset is asserted.
  always_comb begin
    ram_wea    = 4'b0000;
    ram_addra  = pipe_addr;
    ram_dina   = pipe_wdata;
    pipe_stall = 1'b0;
    if (reset) begin
      ram_wea    = 4'b0000;
      pipe_stall = 1'b0;
    end else if (grant_s) begin
      // Only a forced grant steals a cycle the pipeline wanted.
      ram_addra  = dbg_addr;
      ram_wea    = 4'b0000;
      pipe_stall = force_s;
    end else if (pipe_en) begin
      ram_wea    = pipe_we;
    end else begin
      ram_wea    = 4'b0000;
    end
  end

  assign dbg_ack   = dbg_ack_r;
  assign dbg_rdata = dbg_rdata_r;

endmodule
